// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU sequencer: state encoding, opcodes,
// branch condition codes and flag bit positions.
package cpu_pkg;

   localparam int CPU_PC_W    = 4;
   localparam int CPU_INSTR_W = 16;
   localparam int CPU_FLAG_W  = 4;

   // Sequencer states, 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_t;

   localparam logic [3:0] OP_BRANCH = 4'hF;
   localparam logic [3:0] OP_HALT   = 4'hE;

   // Branch condition field ir[11:10]
   typedef enum logic [1:0] {
      COND_ALWAYS = 2'b00,
      COND_Z      = 2'b01,
      COND_NZ     = 2'b10,
      COND_N      = 2'b11
   } cond_t;

   // Flag bit order {V,C,N,Z}
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   // Every opcode other than BRANCH and HALT is an ALU operation
   function automatic logic is_alu_op(input logic [3:0] op);
      return !(op == OP_BRANCH || op == OP_HALT);
   endfunction

endpackage

// File: rtl/cpu_branch_unit.sv
// Branch resolution: evaluates the condition against the latched flags and
// selects the next program counter (branch target or sequential pc+1).
module cpu_branch_unit
   import cpu_pkg::*;
#(
   parameter int PC_W = CPU_PC_W
) (
   input  logic [3:0]      opcode,
   input  logic [1:0]      cond,
   input  logic            flag_z,
   input  logic            flag_n,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] next_pc
);

   logic cond_true;

   // Condition evaluation and next-pc selection
   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      cond_true = 1'b0;
      next_pc   = pc + PC_W'(1);
      unique case (cond_t'(cond))
         COND_ALWAYS: cond_true = 1'b1;
         COND_Z:      cond_true = flag_z;
         COND_NZ:     cond_true = !flag_z;
         COND_N:      cond_true = flag_n;
      endcase
      if (opcode == OP_BRANCH && cond_true) next_pc = target;
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns pc, ir and architectural flags and
// walks FETCH/DECODE/EXECUTE/WRITEBACK for each instruction.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int PC_W    = CPU_PC_W,
   parameter int INSTR_W = CPU_INSTR_W,
   parameter int FLAG_W  = CPU_FLAG_W
) (
   input  logic               clk1,
   input  logic               reset,
   input  logic               run,
   input  logic               step,
   input  logic [INSTR_W-1:0] instr,
   input  logic [FLAG_W-1:0]  alu_flags,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] ir,
   output logic               reg_we,
   output logic [FLAG_W-1:0]  flags_q,
   output logic               busy,
   output logic               halted
);

   state_t            state, state_nxt;
   logic [FLAG_W-1:0] cap_flags;
   logic [PC_W-1:0]   next_pc;
   logic [3:0]        opcode;
   logic              alu_op;

   assign opcode = ir[15:12];
   assign alu_op = is_alu_op(opcode);

   cpu_branch_unit #(.PC_W(PC_W)) u_branch (
      .opcode  (opcode),
      .cond    (ir[11:10]),
      .flag_z  (flags_q[FLAG_Z]),
      .flag_n  (flags_q[FLAG_N]),
      .pc      (pc),
      .target  (ir[PC_W-1:0]),
      .next_pc (next_pc)
   );

   // State register; reset aborts any instruction in flight
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk1 or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; run wins over step, step only honoured in IDLE
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:      if (run || step) state_nxt = ST_FETCH;
         ST_FETCH:     state_nxt = ST_DECODE;
         ST_DECODE:    state_nxt = (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
         ST_EXECUTE:   state_nxt = ST_WRITEBACK;
         ST_WRITEBACK: state_nxt = run ? ST_FETCH : ST_IDLE;
         ST_HALT:      state_nxt = ST_HALT;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Datapath registers: ir load, flag capture and commit, pc update
   always_ff @(posedge clk1 or negedge reset) begin
      if (!reset) begin
         pc        <= '0;
         ir        <= '0;
         flags_q   <= '0;
         cap_flags <= '0;
      end else begin
         unique case (state)
            ST_FETCH:   ir <= instr;
            ST_EXECUTE: if (alu_op) cap_flags <= alu_flags;
            ST_WRITEBACK: begin
               pc <= next_pc;
               if (alu_op) flags_q <= cap_flags;
            end
            default: ;
         endcase
      end
   end

   assign reg_we = (state == ST_WRITEBACK) && alu_op;
   assign busy   = (state == ST_FETCH) || (state == ST_DECODE) ||
                   (state == ST_EXECUTE) || (state == ST_WRITEBACK);
   assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: hand sequences for reset, latency,
// wrap, step, halt and async reset; a branch vector table; and randomized
// programs checked against an instruction-level reference model.
module tb_cpu_sequencer;
   import cpu_pkg::*;

   logic        clk1 = 1'b0;
   logic        reset, run, step;
   logic [15:0] instr, ir;
   logic [3:0]  alu_flags, pc, flags_q;
   logic        reg_we, busy, halted;

   logic [15:0] rom [16];
   int n_tests = 0;
   int n_fail  = 0;
   int we_seen, we_consec;
   logic prev_we;

   cpu_sequencer dut (
      .clk1      (clk1),
      .reset     (reset),
      .run       (run),
      .step      (step),
      .instr     (instr),
      .alu_flags (alu_flags),
      .pc        (pc),
      .ir        (ir),
      .reg_we    (reg_we),
      .flags_q   (flags_q),
      .busy      (busy),
      .halted    (halted)
   );

   // Fetch ROM and a stand-in ALU whose flags come from ir[7:4]
   assign instr     = rom[pc];
   assign alu_flags = ir[7:4];

   always #5 clk1 = ~clk1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock, then sample just after the edge and track write strobes
   task automatic tick();
      @(posedge clk1);
      #1;
      if (reg_we) we_seen++;
      if (reg_we && prev_we) we_consec++;
      prev_we = reg_we;
   endtask

   task automatic apply_reset();
      @(negedge clk1);
      reset = 1'b0;
      @(negedge clk1);
      reset = 1'b1;
      we_seen = 0; we_consec = 0; prev_we = 1'b0;
   endtask

   function automatic logic [15:0] alu_word(input logic [3:0] op, input logic [3:0] nib);
      return {op, 4'h0, nib, 4'h0};
   endfunction

   // Instruction-level reference: one architectural step of the program
   function automatic logic cond_holds(input logic [1:0] c, input logic [3:0] fl);
      case (c)
         2'b00:   return 1'b1;
         2'b01:   return fl[0];
         2'b10:   return !fl[0];
         default: return fl[1];
      endcase
   endfunction

   typedef struct {
      logic [3:0] alu_nib;
      logic [1:0] cond;
      logic [3:0] target;
      logic [3:0] exp_pc;
   } br_vec_t;

   br_vec_t vecs [8];

   initial begin
      logic [3:0] pc_m, fl_m;
      logic [15:0] w;
      int edges;
      int exp_we;

      reset = 1'b0; run = 1'b1; step = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = alu_word(4'h1, 4'h0);

      // Reset with run=1: everything quiet
      #12;
      check("rst_pc", pc, 0);
      check("rst_ir", ir, 0);
      check("rst_flags", flags_q, 0);
      check("rst_we", reg_we, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);

      // First write strobe four edges after release (IDLE->F->D->E->WB)
      for (int i = 0; i < 16; i++) rom[i] = alu_word(4'(i % 14), 4'(i));
      @(negedge clk1);
      reset = 1'b1;
      we_seen = 0; we_consec = 0; prev_we = 1'b0;
      edges = 0;
      while (!reg_we && edges < 20) begin
         tick();
         edges++;
      end
      check("first_we_latency", edges, 4);
      check("pc_in_first_wb", pc, 0);
      tick();
      check("pc_after_first", pc, 1);
      check("busy_free_run", busy, 1);

      // Free-run 16 ALU ops: pc wraps 15->0, strobes never back-to-back
      apply_reset();
      tick();
      we_seen = 0; we_consec = 0;
      repeat (64) tick();
      check("wrap_pc", pc, 0);
      check("wrap_we_count", we_seen, 16);
      check("wrap_we_consecutive", we_consec, 0);
      check("wrap_flags", flags_q, 4'hF);

      // Branch vector table: ALU op sets flags, then branch at pc=1
      vecs[0] = '{4'b0001, 2'b01, 4'h9, 4'h9};
      vecs[1] = '{4'b0000, 2'b01, 4'h9, 4'h2};
      vecs[2] = '{4'b0000, 2'b10, 4'h7, 4'h7};
      vecs[3] = '{4'b0001, 2'b10, 4'h7, 4'h2};
      vecs[4] = '{4'b0010, 2'b11, 4'hC, 4'hC};
      vecs[5] = '{4'b1101, 2'b11, 4'hC, 4'h2};
      vecs[6] = '{4'b0000, 2'b00, 4'h5, 4'h5};
      vecs[7] = '{4'b1110, 2'b01, 4'h3, 4'h2};
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < 16; i++) rom[i] = alu_word(4'h2, 4'h0);
         rom[0] = alu_word(4'h3, vecs[v].alu_nib);
         // Branch's own ALU output is the inverse, so using it would flip the outcome
         rom[1] = {OP_BRANCH, vecs[v].cond, 2'b00, ~vecs[v].alu_nib, vecs[v].target};
         run = 1'b1;
         apply_reset();
         tick();
         we_seen = 0;
         repeat (8) tick();
         check($sformatf("br%0d_pc", v), pc, vecs[v].exp_pc);
         check($sformatf("br%0d_we", v), we_seen, 1);
         check($sformatf("br%0d_flags", v), flags_q, vecs[v].alu_nib);
      end

      // Single step: second pulse while busy is ignored
      for (int i = 0; i < 16; i++) rom[i] = alu_word(4'h4, 4'h0);
      run = 1'b0;
      apply_reset();
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_busy", busy, 1);
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (8) tick();
      check("step_we_count", we_seen, 1);
      check("step_pc", pc, 1);
      check("step_idle", busy, 0);
      check("step_not_halted", halted, 0);

      // run dropped mid-instruction: it completes, then IDLE
      run = 1'b1;
      apply_reset();
      tick();
      run = 1'b0;
      repeat (8) tick();
      check("rundrop_we_count", we_seen, 1);
      check("rundrop_pc", pc, 1);
      check("rundrop_idle", busy, 0);

      // HALT at pc=5 is absorbing
      rom[5] = 16'hE000;
      run = 1'b1;
      apply_reset();
      tick();
      repeat (20) tick();
      check("halt_reach_pc", pc, 5);
      we_seen = 0;
      step = 1'b1;
      repeat (12) tick();
      step = 1'b0;
      check("halt_halted", halted, 1);
      check("halt_busy", busy, 0);
      check("halt_pc", pc, 5);
      check("halt_no_we", we_seen, 0);
      check("halt_ir", ir, 16'hE000);
      apply_reset();
      check("halt_cleared", halted, 0);
      check("halt_clear_pc", pc, 0);

      // Async reset during EXECUTE of the second ALU op
      rom[0] = alu_word(4'h5, 4'hA);
      rom[1] = alu_word(4'h6, 4'h5);
      apply_reset();
      tick();
      repeat (4) tick();
      check("mid_pre_pc", pc, 1);
      check("mid_pre_flags", flags_q, 4'hA);
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      check("mid_rst_pc", pc, 0);
      check("mid_rst_flags", flags_q, 0);
      check("mid_rst_we", reg_we, 0);
      check("mid_rst_busy", busy, 0);
      repeat (3) tick();
      check("mid_rst_no_write", we_seen, 1);
      @(negedge clk1);
      reset = 1'b1;

      // Randomized programs against the instruction-level model
      for (int prog = 0; prog < 3; prog++) begin
         for (int i = 0; i < 16; i++) begin
            w = 16'($urandom);
            if (w[15:12] == OP_HALT) w[15:12] = 4'h2;
            rom[i] = w;
         end
         run = 1'b1;
         apply_reset();
         tick();
         pc_m = '0;
         fl_m = '0;
         for (int k = 0; k < 30; k++) begin
            w = rom[pc_m];
            if (w[15:12] == OP_BRANCH) begin
               exp_we = 0;
               pc_m = cond_holds(w[11:10], fl_m) ? w[3:0] : pc_m + 4'd1;
            end else begin
               exp_we = 1;
               fl_m = w[7:4];
               pc_m = pc_m + 4'd1;
            end
            we_seen = 0;
            repeat (4) tick();
            check($sformatf("rnd%0d_%0d_pc", prog, k), pc, pc_m);
            check($sformatf("rnd%0d_%0d_flags", prog, k), flags_q, fl_m);
            check($sformatf("rnd%0d_%0d_we", prog, k), we_seen, exp_we);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
